// File: rtl/fpmul_pkg.sv
// Shared types and constants for the 11-bit float multiplier scheduler.
// Operand format: 1 sign bit, 6 exponent bits (bias 31), 4 mantissa bits with a hidden leading 1.
package fpmul_pkg;

    localparam int FP_W     = 11;
    localparam int EXP_W    = 6;
    localparam int MAN_W    = 4;
    localparam int BIAS     = 31;
    // Tag ids are sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp11_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at ptr and grants the first set bit as a one-hot vector.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic           found
);

    int idx;

    // NOTE: every output gets a default before the loop, so no path through the block leaves a value held (no latch).
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpmul_rr_sched.sv
// Shares one fixed-latency float multiplier among N requesters.
// Grants are round-robin, each requester has at most one operation outstanding, and every product is routed back by tag.
module fpmul_rr_sched
    import fpmul_pkg::*;
#(
    parameter int N       = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [FP_W*N-1:0] req_a,
    input  logic [FP_W*N-1:0] req_b,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ready,
    output logic [FP_W*N-1:0] rsp_data,
    output logic              mul_in_ready,
    output logic [FP_W-1:0]   mul_a,
    output logic [FP_W-1:0]   mul_b,
    input  logic [FP_W-1:0]   mul_product,
    output logic              busy
);

    localparam int DEPTH = MUL_LAT + 1;

    logic [IDW-1:0] ptr;
    logic [N-1:0]   pending;
    logic [N-1:0]   eligible;
    logic [N-1:0]   grant;
    logic [IDW-1:0] winner;
    logic           found;
    fp11_t          win_a;
    fp11_t          win_b;
    tag_t           tags [DEPTH];

    // A requester stays blocked from its grant until its product has been consumed.
    always_comb begin
        pending = rsp_valid;
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (tags[s].vld && tags[s].id == TAG_ID_W'(i)) begin
                    pending[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = req_valid & ~pending;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req    (eligible),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    assign req_ready = grant;
    assign win_a     = req_a[int'(winner)*FP_W +: FP_W];
    assign win_b     = req_b[int'(winner)*FP_W +: FP_W];

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            mul_in_ready <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            // NOTE: the tag shift register is reset so operations in flight at reset are dropped and never answered.
            for (int s = 0; s < DEPTH; s++) begin
                tags[s] <= '0;
            end
        end else begin
            mul_in_ready <= found;
            if (found) begin
                mul_a <= win_a;
                mul_b <= win_b;
                ptr   <= (winner == IDW'(N-1)) ? '0 : winner + 1'b1;
            end
            tags[0] <= '{vld: found, id: TAG_ID_W'(winner)};
            for (int s = 1; s < DEPTH; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    // The head tag lines up with the cycle in which mul_product holds that operation's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (tags[MUL_LAT].vld && tags[MUL_LAT].id == TAG_ID_W'(i)) begin
                    rsp_valid[i]               <= 1'b1;
                    rsp_data[i*FP_W +: FP_W]   <= mul_product;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i]               <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int s = 0; s < DEPTH; s++) begin
            busy = busy | tags[s].vld;
        end
    end

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// Self-checking bench for fpmul_rr_sched: directed vectors, scenario sequences, and a randomized
// run compared cycle by cycle against a transaction-level model of grants, in-flight operations and held responses.
module tb_fpmul_rr_sched;
    import fpmul_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int LAT_L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MUL_LAT = 1)
    logic [N-1:0]      req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
    logic [FP_W*N-1:0] req_a = '0, req_b = '0, rsp_data;
    logic              mul_in_ready, busy;
    logic [FP_W-1:0]   mul_a, mul_b, mul_product;

    // Long-latency instance (MUL_LAT = 3)
    logic [N-1:0]      req_valid_l = '0, req_ready_l, rsp_valid_l, rsp_ready_l = '1;
    logic [FP_W*N-1:0] req_a_l = '0, req_b_l = '0, rsp_data_l;
    logic              mul_in_ready_l, busy_l;
    logic [FP_W-1:0]   mul_a_l, mul_b_l, mul_product_l;

    fpmul_rr_sched #(.N(N), .MUL_LAT(LAT), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .mul_in_ready(mul_in_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .busy(busy)
    );

    fpmul_rr_sched #(.N(N), .MUL_LAT(LAT_L), .IDW(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_l), .req_ready(req_ready_l),
        .req_a(req_a_l), .req_b(req_b_l), .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready_l),
        .rsp_data(rsp_data_l), .mul_in_ready(mul_in_ready_l), .mul_a(mul_a_l), .mul_b(mul_b_l),
        .mul_product(mul_product_l), .busy(busy_l)
    );

    // Behavioural float multiply: truncating, flush-to-zero, saturating.
    function automatic logic [FP_W-1:0] fmul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        fp11_t      x, y;
        int         e;
        logic [9:0] p;
        logic [3:0] m;
        logic       s;
        x = a;
        y = b;
        s = x.sign ^ y.sign;
        if (x.exp == 0 || y.exp == 0) return '0;
        p = {1'b1, x.man} * {1'b1, y.man};
        e = int'(x.exp) + int'(y.exp) - BIAS;
        if (p[9]) begin
            m = p[8:5];
            e++;
        end else begin
            m = p[7:4];
        end
        if (e <= 0) return '0;
        if (e > 63) return {s, 6'h3F, 4'hF};
        return {s, 6'(e), m};
    endfunction

    // Fixed-latency multiplier models feeding each instance.
    logic [FP_W-1:0] mp   [LAT];
    logic [FP_W-1:0] mp_l [LAT_L];
    always_ff @(posedge clk) begin
        mp[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        mp_l[0] <= fmul(mul_a_l, mul_b_l);
        for (int k = 1; k < LAT_L; k++) mp_l[k] <= mp_l[k-1];
    end
    assign mul_product   = mp[LAT-1];
    assign mul_product_l = mp_l[LAT_L-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: countdown per in-flight op, held response per requester.
    int              m_ptr;
    int              m_cnt  [N];
    bit              m_rv   [N];
    logic [FP_W-1:0] m_rd   [N];
    logic [FP_W-1:0] m_prod [N];
    bit              m_issue;
    logic [FP_W-1:0] m_a, m_b;
    logic [FP_W-1:0] op_a [N];
    logic [FP_W-1:0] op_b [N];
    int              last_grant;

    task automatic model_reset();
        m_ptr = 0;
        m_issue = 0;
        m_a = '0;
        m_b = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_rv[i]  = 0;
            m_rd[i]  = '0;
        end
    endtask

    function automatic logic [FP_W-1:0] rand_fp();
        return {1'($urandom), 6'($urandom_range(24, 38)), 4'($urandom)};
    endfunction

    // Called at posedge+1; drives inputs, compares all outputs, advances the model across the next edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr);
        int  g;
        bit  any_busy;
        logic [N-1:0] exp_ready;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*FP_W +: FP_W] = op_a[i];
            req_b[i*FP_W +: FP_W] = op_b[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && m_cnt[idx] == 0 && !m_rv[idx]) g = idx;
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        any_busy = 0;
        for (int i = 0; i < N; i++) any_busy |= (m_cnt[i] > 0) || m_rv[i];
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mul_in_ready", 32'(mul_in_ready), 32'(m_issue));
        if (m_issue) begin
            check("mul_a", 32'(mul_a), 32'(m_a));
            check("mul_b", 32'(mul_b), 32'(m_b));
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
            check($sformatf("rsp_data[%0d]", i), 32'(rsp_data[i*FP_W +: FP_W]), 32'(m_rd[i]));
        end
        check("busy", 32'(busy), 32'(any_busy));
        last_grant = g;
        for (int i = 0; i < N; i++) if (m_rv[i] && rr[i]) m_rv[i] = 0;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_rv[i] = 1;
                    m_rd[i] = m_prod[i];
                end
            end
        end
        if (g >= 0) begin
            m_cnt[g]  = LAT + 1;
            m_prod[g] = fmul(op_a[g], op_b[g]);
            m_ptr     = (g + 1) % N;
            m_issue   = 1;
            m_a       = op_a[g];
            m_b       = op_b[g];
        end else begin
            m_issue = 0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [FP_W-1:0] p;
    } vec_t;

    vec_t vecs [6];
    int   grants [$];
    int   g1, others, k;

    initial begin
        vecs[0] = '{a: 11'h1F8, b: 11'h200, p: 11'h208};  // 1.5 * 2.0 = 3.0
        vecs[1] = '{a: 11'h1F0, b: 11'h1F0, p: 11'h1F0};  // 1.0 * 1.0
        vecs[2] = '{a: 11'h5F8, b: 11'h200, p: 11'h608};  // -1.5 * 2.0
        vecs[3] = '{a: 11'h1F8, b: 11'h1F8, p: 11'h202};  // 1.5 * 1.5 = 2.25
        vecs[4] = '{a: 11'h1F4, b: 11'h1F4, p: 11'h1F9};  // 1.25 * 1.25 = 1.5625
        vecs[5] = '{a: 11'h208, b: 11'h1E0, p: 11'h1F8};  // 3.0 * 0.5

        for (int i = 0; i < N; i++) begin
            op_a[i] = 11'h1F0 + 11'(i);
            op_b[i] = 11'h200 + 11'(2 * i);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset mul_in_ready", 32'(mul_in_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset mul_a", 32'(mul_a), 0);
        rst_n = 1'b1;

        // Contention from reset: grants 0,1,2,3 on consecutive cycles.
        for (int c = 0; c < 8; c++) begin
            step('1, '1);
            grants.push_back(last_grant);
        end
        for (int c = 0; c < 4; c++) check($sformatf("contention grant %0d", c), 32'(grants[c]), 32'(c));
        repeat (6) step('0, '1);

        // Table vectors, one requester at a time, fixed latency checked explicitly.
        for (int j = 0; j < 6; j++) begin
            int r;
            r = j % N;
            op_a[r] = vecs[j].a;
            op_b[r] = vecs[j].b;
            step(N'(1) << r, '1);
            check($sformatf("vec%0d grant", j), 32'(last_grant), 32'(r));
            step('0, '1);
            step('0, '1);
            #1;
            check($sformatf("vec%0d rsp_valid@T+3", j), 32'(rsp_valid[r]), 1);
            check($sformatf("vec%0d product", j), 32'(rsp_data[r*FP_W +: FP_W]), 32'(vecs[j].p));
            @(posedge clk);
            #1;
            // the explicit-check cycle above had rsp_ready high, so the model drops the response too
            m_rv[r] = 0;
            m_issue = 0;
            step('0, '1);
        end

        // Backpressure on requester 1.
        repeat (4) step('0, '1);
        g1 = 0;
        others = 0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = rand_fp();
                op_b[i] = rand_fp();
            end
            step('1, 4'b1101);
            if (last_grant == 1) g1++;
            else if (last_grant >= 0) others++;
        end
        check("bp grants to 1 while held", 32'(g1), 1);
        check("bp others served", 32'(others >= 6), 1);
        repeat (6) step('1, '1);
        repeat (6) step('0, '1);

        // Fairness between 0 and 2.
        grants.delete();
        for (int c = 0; c < 16; c++) begin
            step(4'b0101, '1);
            if (last_grant >= 0) grants.push_back(last_grant);
        end
        check("fair grant count", 32'(grants.size() >= 6), 1);
        for (int c = 1; c < grants.size(); c++) check($sformatf("fair alternate %0d", c), 32'(grants[c] != grants[c-1]), 1);
        repeat (6) step('0, '1);

        // Reset one cycle after issuing to requester 3.
        k = 0;
        do begin
            step(4'b1000, '1);
            k++;
        end while (last_grant != 3 && k < 8);
        check("issue to 3 before reset", 32'(last_grant), 3);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("midreset mul_in_ready", 32'(mul_in_ready), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset rsp_valid", 32'(rsp_valid), 0);
        check("midreset req_ready", 32'(req_ready), 0);
        check("midreset mul_a", 32'(mul_a), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0111, '1);
        check("post-reset first grant", 32'(last_grant), 0);
        for (int c = 0; c < 6; c++) begin
            step(4'b0111, '1);
            check("no stale rsp 3", 32'(rsp_valid[3]), 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] rr;
            for (int i = 0; i < N; i++) begin
                op_a[i] = rand_fp();
                op_b[i] = rand_fp();
                rr[i]   = ($urandom_range(0, 3) != 0);
            end
            step(N'($urandom), rr);
        end
        repeat (8) step('0, '1);

        // Latency parameter on the MUL_LAT = 3 instance.
        req_valid_l = 4'b0001;
        req_a_l[10:0] = 11'h1F0;
        req_b_l[10:0] = 11'h1F0;
        #1;
        check("lat3 grant", 32'(req_ready_l), 1);
        @(posedge clk);
        #1;
        req_valid_l = '0;
        check("lat3 mul_in_ready", 32'(mul_in_ready_l), 1);
        check("lat3 mul_a", 32'(mul_a_l), 32'h1F0);
        k = 1;
        while (!rsp_valid_l[0] && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("lat3 latency", 32'(k), 5);
        check("lat3 product", 32'(rsp_data_l[10:0]), 32'h1F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpmul_rr_sched.md
Name: fpmul_rr_sched

Overview:
- Round-robin scheduler that shares one 11-bit floating-point multiplier among N requesters.
- Number format is 1 sign, 6 exponent (bias 31), 4 mantissa with hidden 1.
- Accepts operand pairs via per-requester valid/ready, issues one operation per cycle, tracks in-flight tags, and routes each product back to its owner through a per-requester response register.
- Sits between compute clients and the single multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- MUL_LAT, 1, cycles from multiplier in_ready-high edge to valid product (fixed, no done reliance).
- IDW, 2, requester-id width, equal to clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  requester i has an operand pair.
- req_ready  out  N  one-hot grant; handshake when valid and ready both high.
- req_a  in  11*N  operand A, requester i in bits [11i+10:11i].
- req_b  in  11*N  operand B, same packing.
- rsp_valid  out  N  product held for requester i.
- rsp_ready  in  N  requester i consumes its product.
- rsp_data  out  11*N  product for requester i, same packing.
- mul_in_ready  out  1  issue strobe to the multiplier.
- mul_a  out  11  registered operand A to the multiplier.
- mul_b  out  11  registered operand B to the multiplier.
- mul_product  in  11  multiplier result.
- busy  out  1  any tag in flight or any rsp_valid high.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rsp_valid, rsp_data, mul_in_ready, mul_a, mul_b, tag pipeline and busy all go to 0.
  - RR pointer goes to 0.
  - In-flight operations are discarded and never responded.
- Eligibility: i is eligible when req_valid[i]=1 and pending[i]=0. pending[i] is set if i has a tag in flight or rsp_valid[i]=1. Each requester has at most one outstanding operation.
- Arbitration:
  - Combinational round-robin starting at ptr; the first eligible index wins.
  - req_ready is one-hot or zero and depends only on req_valid and state. There is no path from mul_product.
  - On handshake, ptr becomes winner+1 mod N. With no handshake, ptr holds.
- Issue:
  - Handshake in cycle T: mul_a/mul_b take the winner's operands at the T edge, and mul_in_ready=1 during T+1.
  - mul_in_ready drops the next cycle unless another handshake occurred in T+1.
  - Back-to-back issue to different requesters is allowed every cycle.
- Tag pipeline:
  - Shift register of {vld, id}, depth MUL_LAT+1, entered at the handshake.
  - When the head vld=1, mul_product is captured into rsp_data[id] and rsp_valid[id] is set.
  - Handshake-to-rsp_valid latency is exactly MUL_LAT+2 cycles.
- Response:
  - rsp_valid[i] clears on the cycle rsp_valid[i] and rsp_ready[i] are both high.
  - rsp_data[i] holds its value until the next capture for i.
  - pending[i] clears one cycle after the consume, so re-grant to i is earliest in the cycle after the consume edge.
- Simultaneous events:
  - Capture for i and consume for i cannot coincide, because of the single-outstanding rule.
  - Capture for i coincident with a grant to j≠i is legal.
- The multiplier's zero-operand behaviour is passed through unchanged. No special-casing of 0 operands or mul_done.
- busy = OR of tag vld bits OR OR of rsp_valid.

Decomposition:
- Package fpmul_pkg holds:
  - FP_W=11, EXP_W=6, MAN_W=4, BIAS=31.
  - Typedef fp11_t as a packed struct {sign, exp, man}.
  - Typedef tag_t {vld, id}.
- One sub-module: rr_arbiter (N-wide request vector and pointer in, one-hot grant out), reusable elsewhere.

Test Plan:
- Single request:
  - Stimulus: req 0 with a=0x1F8 (1.5), b=0x200 (2.0); bench multiplier model with MUL_LAT=1.
  - Required: req_ready[0] same cycle; mul_in_ready at T+1 with mul_a=0x1F8; rsp_valid[0] at T+3 with rsp_data[0]=0x208 (3.0).
- Contention:
  - Stimulus: all 4 requesters valid from reset with distinct operands, rsp_ready tied 1.
  - Required: grants in order 0,1,2,3 on consecutive cycles; mul_in_ready high for 4 consecutive cycles; each response matches its own operands.
- Backpressure:
  - Stimulus: requester 1 holds rsp_ready=0 for 10 cycles while keeping req_valid=1.
  - Required: no second grant to 1 until the cycle after the consume; other requesters continue to be served.
- Pointer fairness:
  - Stimulus: requesters 0 and 2 continuously valid.
  - Required: grants alternate 0,2,0,2; neither requester waits more than 1 grant.
- Reset mid-flight:
  - Stimulus: deassert rst_n one cycle after issuing to requester 3.
  - Required: all outputs 0 immediately; no rsp_valid[3] after release; the first post-reset grant follows the pointer from 0.
- Latency parameter:
  - Stimulus: rebuild with MUL_LAT=3; a=0x1F0 (1.0), b=0x1F0.
  - Required: rsp_valid at T+5 with data 0x1F0.
